// File: rtl/alu_decode_pkg.sv
// Shared opcode constants and the decoded-control record for the ALU decode/issue stage.
package alu_decode_pkg;

    localparam int unsigned ALU_DW  = 32;
    localparam int unsigned ALU_SHW = 5;

    localparam logic [2:0] OPSEL_SHIFT_REG   = 3'b000;
    localparam logic [2:0] OPSEL_ARITH_LOGIC = 3'b001;
    localparam logic [2:0] OPSEL_MEM_WRITE   = 3'b100;
    localparam logic [2:0] OPSEL_MEM_READ    = 3'b101;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_HADD = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_NOT  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_XOR  = 3'b110;
    localparam logic [2:0] OP_LHG  = 3'b111;

    localparam logic [2:0] OP_SHLEFTLOG = 3'b000;
    localparam logic [2:0] OP_SHLEFTART = 3'b001;
    localparam logic [2:0] OP_SHRGHTLOG = 3'b010;
    localparam logic [2:0] OP_SHRGHTART = 3'b011;

    typedef struct packed {
        logic [ALU_DW-1:0]  aluin1;
        logic [ALU_DW-1:0]  aluin2;
        logic [2:0]         opselect;
        logic [2:0]         operation;
        logic [ALU_SHW-1:0] shift_number;
        logic               illegal;
    } alu_ctrl_t;

    // Immediates of the signed arithmetic operations are sign-extended.
    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_HADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/decode_skid_buf.sv
// Two-entry valid/ready skid buffer with registered output and registered upstream ready.
module decode_skid_buf
    import alu_decode_pkg::*;
#(
    parameter type T = alu_ctrl_t
) (
    input  logic clk,
    input  logic rst,
    input  logic i_valid,
    output logic o_ready,
    input  T     i_data,
    output logic o_valid,
    input  logic i_ready,
    output T     o_data
);

    logic [1:0] r_count;
    logic       r_wr;
    logic       r_rd;
    logic       r_ready;
    T           r_slot0;
    T           r_slot1;
    logic       w_push;
    logic       w_pop;
    logic [1:0] w_count_nxt;

    assign w_push = i_valid & r_ready;
    assign w_pop  = (r_count != 2'd0) & i_ready;

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + 2'd1;
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= 2'd0;
            r_wr    <= 1'b0;
            r_rd    <= 1'b0;
            r_ready <= 1'b1;
            r_slot0 <= '0;
            r_slot1 <= '0;
        end else begin
            r_count <= w_count_nxt;
            // Ready drops only once both slots hold beats.
            r_ready <= (w_count_nxt != 2'd2);
            if (w_push) begin
                r_wr <= ~r_wr;
                if (r_wr) begin
                    r_slot1 <= i_data;
                end else begin
                    r_slot0 <= i_data;
                end
            end
            if (w_pop) begin
                r_rd <= ~r_rd;
            end
        end
    end

    assign o_ready = r_ready;
    assign o_valid = (r_count != 2'd0);
    assign o_data  = r_rd ? r_slot1 : r_slot0;

endmodule

// File: rtl/alu_decode_stage.sv
// Decode/issue stage feeding the execute-stage ALU through a 2-entry skid buffer.
// Optional DECODE_ERRCNT_EN adds a saturating illegal-beat counter on err_count.
module alu_decode_stage
    import alu_decode_pkg::*;
#(
    parameter int unsigned DW  = ALU_DW,
    parameter int unsigned SHW = ALU_SHW
`ifdef DECODE_ERRCNT_EN
    ,parameter int unsigned ERRW = 16
`endif
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [31:0]    instr,
    input  logic [DW-1:0]  rs1_data,
    input  logic [DW-1:0]  rs2_data,
    input  logic           out_ready,
    output logic           out_valid,
    output logic [DW-1:0]  aluin1,
    output logic [DW-1:0]  aluin2,
    output logic [2:0]     opselect,
    output logic [2:0]     operation,
    output logic [SHW-1:0] shift_number,
    output logic           enable_shift,
    output logic           enable_arith,
    output logic           illegal
`ifdef DECODE_ERRCNT_EN
    ,output logic [ERRW-1:0] err_count
`endif
);

    logic [2:0]    w_opsel;
    logic [2:0]    w_op;
    logic          w_imm_sel;
    logic [15:0]   w_imm16;
    logic [4:0]    w_shamt;
    logic [DW-1:0] w_imm_ext;
    logic [DW-1:0] w_opb;
    alu_ctrl_t     w_ctrl;
    alu_ctrl_t     w_q;
    logic          w_fire;
    logic          w_unused;

    assign w_opsel   = instr[31:29];
    assign w_op      = instr[28:26];
    assign w_imm_sel = instr[25];
    assign w_imm16   = instr[15:0];
    assign w_shamt   = instr[10:6];
    assign w_unused  = &{1'b0, instr[24:16]};

    always_comb begin
        w_ctrl           = '0;
        w_ctrl.opselect  = w_opsel;
        w_ctrl.operation = w_op;
        w_imm_ext        = is_signed_op(w_op) ? {{(DW-16){w_imm16[15]}}, w_imm16}
                                              : {{(DW-16){1'b0}}, w_imm16};
        w_opb            = w_imm_sel ? w_imm_ext : rs2_data;
        case (w_opsel)
            OPSEL_ARITH_LOGIC: begin
                case (w_op)
                    OP_ADD, OP_HADD, OP_AND, OP_OR, OP_XOR: begin
                        w_ctrl.aluin1 = rs1_data;
                        w_ctrl.aluin2 = w_opb;
                    end
                    // Execute computes aluin2 - aluin1, so operands swap here.
                    OP_SUB: begin
                        w_ctrl.aluin1 = w_opb;
                        w_ctrl.aluin2 = rs1_data;
                    end
                    OP_NOT: w_ctrl.aluin2 = rs1_data;
                    OP_LHG: w_ctrl.aluin2 = {{(DW-16){1'b0}}, w_imm16};
                    default: w_ctrl.illegal = 1'b1;
                endcase
            end
            OPSEL_MEM_READ: w_ctrl.aluin2 = rs2_data;
            OPSEL_SHIFT_REG: begin
                w_ctrl.aluin1       = rs1_data;
                w_ctrl.shift_number = w_imm_sel ? w_shamt : rs2_data[SHW-1:0];
            end
            default: w_ctrl.illegal = 1'b1;
        endcase
    end

    decode_skid_buf #(
        .T(alu_ctrl_t)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_valid (in_valid),
        .o_ready (in_ready),
        .i_data  (w_ctrl),
        .o_valid (out_valid),
        .i_ready (out_ready),
        .o_data  (w_q)
    );

    assign w_fire       = out_valid & out_ready;
    assign aluin1       = w_q.aluin1;
    assign aluin2       = w_q.aluin2;
    assign opselect     = w_q.opselect;
    assign operation    = w_q.operation;
    assign shift_number = w_q.shift_number;
    assign illegal      = out_valid & w_q.illegal;
    assign enable_shift = w_fire & ~w_q.illegal & (w_q.opselect == OPSEL_SHIFT_REG);
    assign enable_arith = w_fire & ~w_q.illegal &
                          ((w_q.opselect == OPSEL_ARITH_LOGIC) || (w_q.opselect == OPSEL_MEM_READ));

`ifdef DECODE_ERRCNT_EN
    logic [ERRW-1:0] r_err_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_count <= '0;
        end else if (w_fire && w_q.illegal && (r_err_count != '1)) begin
            r_err_count <= r_err_count + 1'b1;
        end
    end

    assign err_count = r_err_count;
`endif

endmodule

// File: tb/tb_alu_decode_stage.sv
// Scoreboard bench for alu_decode_stage; covers err_count when DECODE_ERRCNT_EN is defined.
module tb_alu_decode_stage;

    typedef struct packed {
        logic [31:0] a1;
        logic [31:0] a2;
        logic [2:0]  os;
        logic [2:0]  op;
        logic [4:0]  sh;
        logic        ill;
        logic        ea;
        logic        es;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instr = '0;
    logic [31:0] rs1_data = '0;
    logic [31:0] rs2_data = '0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [31:0] aluin1;
    logic [31:0] aluin2;
    logic [2:0]  opselect;
    logic [2:0]  operation;
    logic [4:0]  shift_number;
    logic        enable_shift;
    logic        enable_arith;
    logic        illegal;
`ifdef DECODE_ERRCNT_EN
    logic [15:0] err_count;
`endif

    int   total = 0;
    int   bad = 0;
    int   spurious = 0;
    rec_t q_exp[$];
    rec_t q_got[$];

    alu_decode_stage dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .instr        (instr),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .out_ready    (out_ready),
        .out_valid    (out_valid),
        .aluin1       (aluin1),
        .aluin2       (aluin2),
        .opselect     (opselect),
        .operation    (operation),
        .shift_number (shift_number),
        .enable_shift (enable_shift),
        .enable_arith (enable_arith),
        .illegal      (illegal)
`ifdef DECODE_ERRCNT_EN
        ,.err_count   (err_count)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mk(input logic [2:0] os, input logic [2:0] op,
                                       input logic imm, input logic [15:0] i16);
        return {os, op, imm, 9'h000, i16};
    endfunction

    // Reference decode written straight from the operand-selection rules.
    function automatic rec_t model(input logic [31:0] ins, input logic [31:0] r1,
                                   input logic [31:0] r2);
        rec_t        r;
        logic [31:0] b;
        logic [15:0] i16;
        r    = '0;
        r.os = ins[31:29];
        r.op = ins[28:26];
        i16  = ins[15:0];
        if (ins[25]) b = (r.op <= 3'd2) ? {{16{i16[15]}}, i16} : {16'h0000, i16};
        else         b = r2;
        if (r.os == 3'b001) begin
            r.ea = 1'b1;
            if (r.op == 3'd2)      begin r.a1 = b;  r.a2 = r1; end
            else if (r.op == 3'd3) begin r.a1 = 0;  r.a2 = r1; end
            else if (r.op == 3'd7) begin r.a1 = 0;  r.a2 = {16'h0000, i16}; end
            else                   begin r.a1 = r1; r.a2 = b; end
        end else if (r.os == 3'b101) begin
            r.ea = 1'b1;
            r.a2 = r2;
        end else if (r.os == 3'b000) begin
            r.es = 1'b1;
            r.a1 = r1;
            r.sh = ins[25] ? ins[10:6] : r2[4:0];
        end else begin
            r.ill = 1'b1;
        end
        return r;
    endfunction

    // Data fields are don't-care on illegal beats.
    function automatic rec_t mask(input rec_t r, input logic ill);
        rec_t m;
        m = r;
        if (ill) begin
            m.a1 = '0;
            m.a2 = '0;
            m.sh = '0;
        end
        return m;
    endfunction

    // One cycle: drive at negedge, record accept/deliver, advance to next negedge.
    task automatic beat(input logic v, input logic [31:0] ins, input logic [31:0] r1,
                        input logic [31:0] r2, input logic ordy, output logic took);
        in_valid  = v;
        instr     = ins;
        rs1_data  = r1;
        rs2_data  = r2;
        out_ready = ordy;
        #1;
        took = v && in_ready;
        if (took) q_exp.push_back(model(ins, r1, r2));
        if (out_valid && out_ready)
            q_got.push_back('{aluin1, aluin2, opselect, operation, shift_number,
                              illegal, enable_arith, enable_shift});
        else if (enable_arith || enable_shift)
            spurious++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain(input int budget);
        logic took;
        for (int i = 0; i < budget && q_got.size() < q_exp.size(); i++)
            beat(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, took);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        q_exp.delete();
        q_got.delete();
        spurious = 0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        total++;
        if ({aluin1, aluin2, opselect, operation, shift_number} !== '0) begin
            bad++; $display("FAIL reset_data got=%h/%h exp=0", aluin1, aluin2);
        end
        total++;
        if ({illegal, enable_arith, enable_shift} !== 3'b000) begin
            bad++; $display("FAIL reset_flags got=%b exp=000", {illegal, enable_arith, enable_shift});
        end
`ifdef DECODE_ERRCNT_EN
        total++;
        if (err_count !== 16'd0) begin bad++; $display("FAIL reset_err_count got=%0d exp=0", err_count); end
`endif
    endtask

    task automatic test_basic_ops();
        logic took;
        rec_t g;
        rec_t e;
        do_reset();
        beat(1'b1, mk(3'b001, 3'b000, 1'b1, 16'hFFFF), 32'd5, 32'h1234, 1'b1, took);
        total++;
        if (!(out_valid && aluin1 === 32'd5 && aluin2 === 32'hFFFFFFFF && enable_arith === 1'b1)) begin
            bad++; $display("FAIL add_imm_latency got=%b/%h/%h/%b exp=1/5/ffffffff/1",
                            out_valid, aluin1, aluin2, enable_arith);
        end
        beat(1'b1, mk(3'b001, 3'b010, 1'b0, 16'h0), 32'd10, 32'd3, 1'b1, took);
        beat(1'b1, mk(3'b000, 3'b000, 1'b1, 16'd7 << 6), 32'h1, 32'h1F, 1'b1, took);
        drain(10);
        total++;
        if (q_got.size() != 3) begin
            bad++; $display("FAIL basic_count got=%0d exp=3", q_got.size());
        end else begin
            total++;
            if (q_got[1].a1 !== 32'd3 || q_got[1].a2 !== 32'd10 || q_got[1].ea !== 1'b1 || q_got[1].es !== 1'b0) begin
                bad++; $display("FAIL sub_reg got=%h/%h/%b/%b exp=3/a/1/0",
                                q_got[1].a1, q_got[1].a2, q_got[1].ea, q_got[1].es);
            end
            total++;
            if (q_got[2].a1 !== 32'h1 || q_got[2].sh !== 5'd7 || q_got[2].es !== 1'b1 || q_got[2].ea !== 1'b0) begin
                bad++; $display("FAIL shift_imm got=%h/%0d/%b exp=1/7/1", q_got[2].a1, q_got[2].sh, q_got[2].es);
            end
        end
        while (q_got.size() > 0 && q_exp.size() > 0) begin
            g = q_got.pop_front();
            e = q_exp.pop_front();
            total++;
            if (mask(g, e.ill) !== mask(e, e.ill)) begin
                bad++; $display("FAIL basic_sb got=%h exp=%h", g, e);
            end
        end
    endtask

    task automatic test_stall();
        logic        took;
        logic        c_taken;
        rec_t        g;
        rec_t        e;
        logic [31:0] head_a1;
        do_reset();
        beat(1'b1, mk(3'b001, 3'b000, 1'b0, 16'h0), 32'hA0, 32'hA1, 1'b0, took);
        beat(1'b1, mk(3'b001, 3'b100, 1'b1, 16'h8001), 32'hB0, 32'hB1, 1'b0, took);
        head_a1 = 32'hA0;
        beat(1'b1, mk(3'b000, 3'b011, 1'b0, 16'h0), 32'hC0, 32'hC5, 1'b0, took);
        total++;
        if (took !== 1'b0 || in_ready !== 1'b0 || q_exp.size() != 2) begin
            bad++; $display("FAIL stall_full got=took%b/rdy%b/acc%0d exp=0/0/2", took, in_ready, q_exp.size());
        end
        total++;
        if (out_valid !== 1'b1 || aluin1 !== head_a1) begin
            bad++; $display("FAIL stall_frozen got=%b/%h exp=1/%h", out_valid, aluin1, head_a1);
        end
        total++;
        if (spurious != 0 || q_got.size() != 0) begin
            bad++; $display("FAIL stall_enables got=%0d/%0d exp=0/0", spurious, q_got.size());
        end
        c_taken = 1'b0;
        for (int i = 0; i < 6 && !c_taken; i++)
            beat(1'b1, mk(3'b000, 3'b011, 1'b0, 16'h0), 32'hC0, 32'hC5, 1'b1, c_taken);
        total++;
        if (c_taken !== 1'b1) begin bad++; $display("FAIL stall_third_accept got=0 exp=1"); end
        drain(10);
        total++;
        if (q_got.size() != 3 || q_exp.size() != 3) begin
            bad++; $display("FAIL stall_count got=%0d exp=%0d", q_got.size(), q_exp.size());
        end
        while (q_got.size() > 0 && q_exp.size() > 0) begin
            g = q_got.pop_front();
            e = q_exp.pop_front();
            total++;
            if (mask(g, e.ill) !== mask(e, e.ill)) begin
                bad++; $display("FAIL stall_sb got=%h exp=%h", g, e);
            end
        end
    endtask

    task automatic test_illegal();
        logic took;
        rec_t g;
        rec_t e;
        do_reset();
        for (int i = 0; i < 3; i++)
            beat(1'b1, mk(3'b111, 3'(i), 1'b1, 16'h1234), 32'd9, 32'd8, 1'b1, took);
        drain(10);
        total++;
        if (q_got.size() != 3) begin bad++; $display("FAIL illegal_count got=%0d exp=3", q_got.size()); end
        while (q_got.size() > 0 && q_exp.size() > 0) begin
            g = q_got.pop_front();
            e = q_exp.pop_front();
            total++;
            if (g.ill !== 1'b1 || g.ea !== 1'b0 || g.es !== 1'b0 || mask(g, 1'b1) !== mask(e, 1'b1)) begin
                bad++; $display("FAIL illegal_sb got=%h exp=%h", g, e);
            end
        end
`ifdef DECODE_ERRCNT_EN
        total++;
        if (err_count !== 16'd3) begin bad++; $display("FAIL err_count got=%0d exp=3", err_count); end
`endif
    endtask

    task automatic test_back_to_back();
        logic        took;
        int          acc;
        logic [2:0]  os;
        logic [2:0]  os_tab [6] = '{3'b000, 3'b001, 3'b001, 3'b101, 3'b100, 3'b111};
        rec_t        g;
        rec_t        e;
        do_reset();
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            beat(1'b1, mk(3'b001, 3'(i), 1'(i % 2), 16'(16'h8000 + i)), $urandom, $urandom, 1'b1, took);
            if (took) acc++;
        end
        total++;
        if (acc != 8) begin bad++; $display("FAIL b2b_throughput got=%0d exp=8", acc); end
        for (int i = 0; i < 60; i++) begin
            os = os_tab[$urandom_range(0, 5)];
            beat(1'($urandom_range(0, 1)), {os, 3'($urandom), 1'($urandom), 9'($urandom), 16'($urandom)},
                 $urandom, $urandom, 1'($urandom_range(0, 3) != 0), took);
        end
        drain(20);
        total++;
        if (q_got.size() != q_exp.size() || spurious != 0) begin
            bad++; $display("FAIL b2b_count got=%0d/%0d exp=%0d/0", q_got.size(), spurious, q_exp.size());
        end
        while (q_got.size() > 0 && q_exp.size() > 0) begin
            g = q_got.pop_front();
            e = q_exp.pop_front();
            total++;
            if (mask(g, e.ill) !== mask(e, e.ill)) begin
                bad++; $display("FAIL b2b_sb got=%h exp=%h", g, e);
            end
        end
    endtask

    task automatic test_reset_midstall();
        logic took;
        do_reset();
        beat(1'b1, mk(3'b001, 3'b000, 1'b0, 16'h0), 32'd1, 32'd2, 1'b0, took);
        beat(1'b1, mk(3'b000, 3'b000, 1'b0, 16'h0), 32'd3, 32'd4, 1'b0, took);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        rst       = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL midstall_reset got=%b/%b exp=0/1", out_valid, in_ready);
        end
        total++;
        if (enable_arith !== 1'b0 || enable_shift !== 1'b0) begin
            bad++; $display("FAIL midstall_enables got=%b/%b exp=0/0", enable_arith, enable_shift);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || enable_arith !== 1'b0 || enable_shift !== 1'b0) begin
            bad++; $display("FAIL midstall_after got=%b exp=0", out_valid);
        end
        q_exp.delete();
        q_got.delete();
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic_ops();
        test_stall();
        test_illegal();
        test_back_to_back();
        test_reset_midstall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
